// File: rtl/fifo_uart_tx.sv
// Drains bytes from the 8-entry FIFO read port and sends each one as an 8N1 frame on tx.
// One FIFO read per frame; tx_en is only consulted between frames.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic [2:0] o_dbg_state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            r_fifo_rd;
    logic            w_rd_next;
    logic [7:0]      r_frame_cnt;
    logic            w_baud_end;
    logic            w_frame_done;

    assign w_baud_end = (r_baud == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (tx_en && !fifo_empty) w_state_next = S_POP;
            S_POP:   w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_START;
            S_START: if (w_baud_end) w_state_next = S_DATA;
            S_DATA:  if (w_baud_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_baud_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Read handshake: fifo_rd pulses for the single POP cycle and fifo_data is
    // valid in the following (LOAD) cycle, where it is captured.
    // tx and fifo_rd are registered, so they are derived from the next state.
    always_comb begin
        w_shift_next = r_shift;
        if (r_state == S_LOAD) begin
            w_shift_next = fifo_data;
        end else if ((r_state == S_DATA) && w_baud_end) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
        w_rd_next    = (w_state_next == S_POP);
        w_frame_done = (r_state == S_STOP) && w_baud_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud      <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_tx        <= 1'b1;
            r_fifo_rd   <= 1'b0;
            r_frame_cnt <= 8'h00;
        end else begin
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_fifo_rd <= w_rd_next;
            if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
                r_baud <= w_baud_end ? '0 : r_baud + BW'(1);
            end else begin
                r_baud <= '0;
            end
            if (r_state == S_LOAD) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_baud_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign fifo_rd     = r_fifo_rd;
    assign tx          = r_tx;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = w_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds the DUT, a serial receiver decodes tx
// and compares every frame against the bytes queued by the stimulus.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic [2:0] dbg_state;
    logic       wr_en;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .o_dbg_state(dbg_state)
    );

    // FIFO model: registered data_out and registered empty flag
    logic [7:0] mem_q[$];
    int underflow_cnt = 0;
    always @(posedge clk) begin
        if (fifo_rd) begin
            if (mem_q.size() == 0) underflow_cnt <= underflow_cnt + 1;
            else fifo_data <= mem_q.pop_front();
        end
        if (wr_en) mem_q.push_back(wr_data);
        fifo_empty <= (mem_q.size() == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int rd_count = 0;
    int done_count = 0;
    int last_rd_cyc = 0;
    int prev_rd_cyc = 0;
    int done_cyc = 0;
    int gap_cnt = 0;
    int last_gap = 0;

    // Monitor: serial receiver sampling on the falling edge
    initial begin : monitor
        bit         rx_active;
        int         rx_cnt;
        int         glitch;
        logic [9:0] frame_bits;
        logic [7:0] exp_b;
        rx_active  = 1'b0;
        rx_cnt     = 0;
        glitch     = 0;
        frame_bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_active = 1'b0;
                gap_cnt   = 0;
            end else begin
                if (fifo_rd) begin
                    rd_count++;
                    prev_rd_cyc = last_rd_cyc;
                    last_rd_cyc = cyc;
                end
                if (frame_done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (!rx_active) begin
                    if (frame_done) check("frame_done_stray", 1, 0);
                    if (tx == 1'b0) begin
                        rx_active     = 1'b1;
                        rx_cnt        = 0;
                        glitch        = 0;
                        last_gap      = gap_cnt;
                        frame_bits[0] = 1'b0;
                    end else begin
                        gap_cnt++;
                    end
                end else begin
                    rx_cnt++;
                    if (rx_cnt % CPB == 0) frame_bits[rx_cnt / CPB] = tx;
                    else if (tx != frame_bits[rx_cnt / CPB]) glitch++;
                    if (rx_cnt == 10 * CPB - 1) begin
                        check("frame_done_last_stop", int'(frame_done), 1);
                        check("bit_glitch", glitch, 0);
                        check("start_bit", int'(frame_bits[0]), 0);
                        check("stop_bit", int'(frame_bits[9]), 1);
                        if (exp_q.size() == 0) begin
                            check("frame_without_expected_byte", 1, 0);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("rx_byte", int'(frame_bits[8:1]), int'(exp_b));
                        end
                        rx_active = 1'b0;
                        gap_cnt   = 0;
                    end else if (frame_done) begin
                        check("frame_done_stray", 1, 0);
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_count < target) check("frame_done_timeout", done_count, target);
    endtask

    task automatic wait_rd(input int target, input int budget);
        int n = 0;
        while (rd_count < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rd_count < target) check("fifo_rd_timeout", rd_count, target);
    endtask

    initial begin : stimulus
        int bad;
        int base;
        rst     = 1'b1;
        tx_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with a non-empty FIFO and tx_en high
        push_byte(8'hA5);
        tx_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_tx", int'(tx), 1);
            check("reset_fifo_rd", int'(fifo_rd), 0);
            check("reset_busy", int'(busy), 0);
            check("reset_frame_cnt", int'(frame_cnt), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rd_one_cycle_after_release", int'(fifo_rd), 1);
        check("busy_in_pop", int'(busy), 1);

        // Single frame 0xA5: read to frame_done is 1 + 40 cycles
        wait_done(1, 200);
        check("a5_frame_cnt", int'(frame_cnt), 1);
        check("a5_busy_after", int'(busy), 0);
        check("a5_rd_count", rd_count, 1);
        check("a5_rd_to_done", done_cyc - last_rd_cyc, 41);

        // Back-to-back 0x00, 0xFF: frame_cnt is cumulative (1 + 2)
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_done(3, 300);
        check("b2b_frame_cnt", int'(frame_cnt), 3);
        check("b2b_rd_spacing", last_rd_cyc - prev_rd_cyc, 43);
        check("b2b_idle_gap", last_gap, 3);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_no_third_read", rd_count, 3);

        // Empty FIFO with tx_en high
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (fifo_rd || !tx || busy) bad++;
        end
        check("empty_idle_violations", bad, 0);
        check("empty_rd_count", rd_count, 3);

        // tx_en dropped during data bit 3 with two bytes queued
        push_byte(8'h3C);
        push_byte(8'h96);
        wait_rd(4, 50);
        repeat (18) @(posedge clk);
        #1;
        check("txen_drop_in_data", int'(dbg_state), 4);
        tx_en = 1'b0;
        wait_done(4, 200);
        check("txen_frame_cnt", int'(frame_cnt), 4);
        repeat (60) @(posedge clk);
        #1;
        check("txen_hold_rd_count", rd_count, 4);
        check("txen_hold_busy", int'(busy), 0);
        tx_en = 1'b1;
        wait_done(5, 200);
        check("txen_resume_frame_cnt", int'(frame_cnt), 5);
        check("txen_resume_rd_count", rd_count, 5);

        // Reset mid-DATA: byte is abandoned and never re-read
        push_byte(8'h5A);
        wait_rd(6, 50);
        repeat (9) @(posedge clk);
        #1;
        check("midreset_in_data", int'(dbg_state), 4);
        rst = 1'b1;
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        check("midreset_tx", int'(tx), 1);
        check("midreset_frame_cnt", int'(frame_cnt), 0);
        check("midreset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("midreset_no_reread", rd_count, 6);

        // 256 frames: frame_cnt wraps to 0
        base = done_count;
        for (int i = 0; i < 256; i++) begin
            push_byte(8'(i * 37 + 11));
            if ((i % 8 == 7) && (i != 255)) wait_done(base + i + 1, 1000);
        end
        wait_done(base + 255, 1000);
        check("wrap_frame_cnt_255", int'(frame_cnt), 255);
        wait_done(base + 256, 200);
        check("wrap_frame_cnt_0", int'(frame_cnt), 0);
        check("wrap_rd_count", rd_count, 262);

        repeat (10) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("fifo_underflow", underflow_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
